reg_wb_queue: RTL and testbench

- Writeback buffer directly upstream of the 32x32 register file write port.
- Accepts writeback requests (register index + data) from the execute/feature pipeline through a valid/ready handshake.
- Queues requests in a small FIFO and drains them one per cycle into the register file's reg_write/w_reg/w_data port.
- Provides two forwarding lookups so read-port consumers see pending data that has not yet been written.

---
 rtl/reg_wb_queue_if.sv | 27 ++
 rtl/reg_wb_queue.sv | 73 +++++++
 tb/tb_reg_wb_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reg_wb_queue_if.sv
// reg_wb_queue_if: writeback request, register-file write port and forwarding lookup signals
// slave = queue side, master = pipeline/register-file side
interface reg_wb_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32
);
  logic in_valid, in_ready;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic drain_en, reg_write;
  logic [AW-1:0] w_reg;
  logic [DW-1:0] w_data;
  logic [AW-1:0] r_reg1, r_reg2;
  logic fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic [$clog2(DEPTH):0] count;
  logic empty, full;
  modport slave(
    input in_valid, in_reg, in_data, drain_en, r_reg1, r_reg2,
    output in_ready, reg_write, w_reg, w_data, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty, full
  );
  modport master(
    output in_valid, in_reg, in_data, drain_en, r_reg1, r_reg2,
    input in_ready, reg_write, w_reg, w_data, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty, full
  );
endinterface

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: writeback FIFO feeding the register-file write port, with two forwarding lookups
// clk/rst: clock, async active-high reset; q: request handshake, write port, forwarding, status
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input logic clk,
  input logic rst,
  reg_wb_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] reg_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, idx;
  logic [PW:0] cnt_q, cnt_d;
  logic push, pop;
  assign q.empty = cnt_q == '0;
  assign q.full = cnt_q == (PW+1)'(DEPTH);
  assign q.count = cnt_q;
  assign q.in_ready = !q.full;
  assign push = q.in_valid && !q.full;
  assign pop = q.reg_write;
  assign q.reg_write = !q.empty && q.drain_en;
  assign q.w_reg = q.empty ? '0 : reg_q[rp_q];
  assign q.w_data = q.empty ? '0 : data_q[rp_q];
  assign wp_d = push ? wp_q + 1'b1 : wp_q;
  assign rp_d = pop ? rp_q + 1'b1 : rp_q;
  assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  // walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    idx = '0;
    q.fwd_hit1 = 1'b0;
    q.fwd_data1 = '0;
    q.fwd_hit2 = 1'b0;
    q.fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp_q + PW'(k);
      if (vld_q[idx] && reg_q[idx] == q.r_reg1) begin
        q.fwd_hit1 = 1'b1;
        q.fwd_data1 = data_q[idx];
      end
      if (vld_q[idx] && reg_q[idx] == q.r_reg2) begin
        q.fwd_hit2 = 1'b1;
        q.fwd_data2 = data_q[idx];
      end
    end
  end
  // push and pop never target the same slot: equal pointers mean empty (no pop) or full (no push)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        reg_q[k] <= '0;
        data_q[k] <= '0;
      end
      vld_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        reg_q[wp_q] <= q.in_reg;
        data_q[wp_q] <= q.in_data;
        vld_q[wp_q] <= 1'b1;
      end
      if (pop) vld_q[rp_q] <= 1'b0;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue: scoreboard bench for reg_wb_queue against a queue-based reference model
module tb_reg_wb_queue;
  localparam int DEPTH = 4;
  typedef struct {
    logic [4:0] r;
    logic [31:0] d;
  } ent_t;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  ent_t mq[$];
  bit full_m = 0;
  reg_wb_queue_if #(.DEPTH(DEPTH), .AW(5), .DW(32)) q();
  reg_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut(.clk(clk), .rst(rst), .q(q));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: accept a push only if the queue was not full before this edge's pop
  always @(posedge clk)
    if (!rst && q.in_valid && !full_m) mq.push_back('{q.in_reg, q.in_data});

  always @(negedge clk) begin
    logic h1, h2, wr;
    logic [31:0] d1, d2;
    if (rst) begin
      chk("rst_reg_write", q.reg_write, 0);
      chk("rst_w_reg", q.w_reg, 0);
      chk("rst_w_data", q.w_data, 0);
      chk("rst_fwd_hit1", q.fwd_hit1, 0);
      chk("rst_fwd_data1", q.fwd_data1, 0);
      chk("rst_fwd_hit2", q.fwd_hit2, 0);
      chk("rst_fwd_data2", q.fwd_data2, 0);
      chk("rst_count", q.count, 0);
      chk("rst_empty", q.empty, 1);
      chk("rst_full", q.full, 0);
      chk("rst_in_ready", q.in_ready, 1);
      mq.delete();
      full_m = 0;
    end else begin
      h1 = 0; h2 = 0; d1 = 0; d2 = 0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!h1 && mq[i].r == q.r_reg1) begin h1 = 1; d1 = mq[i].d; end
        if (!h2 && mq[i].r == q.r_reg2) begin h2 = 1; d2 = mq[i].d; end
      end
      chk("count", q.count, mq.size());
      chk("empty", q.empty, mq.size() == 0);
      chk("full", q.full, mq.size() == DEPTH);
      chk("in_ready", q.in_ready, mq.size() != DEPTH);
      chk("fwd_hit1", q.fwd_hit1, h1);
      chk("fwd_data1", q.fwd_data1, d1);
      chk("fwd_hit2", q.fwd_hit2, h2);
      chk("fwd_data2", q.fwd_data2, d2);
      wr = mq.size() != 0 && q.drain_en;
      chk("reg_write", q.reg_write, wr);
      chk("w_reg", q.w_reg, mq.size() != 0 ? mq[0].r : 5'd0);
      chk("w_data", q.w_data, mq.size() != 0 ? mq[0].d : 32'd0);
      full_m = mq.size() == DEPTH;
      if (wr) void'(mq.pop_front());
    end
  end

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d, input logic de);
    q.in_valid = v;
    q.in_reg = r;
    q.in_data = d;
    q.drain_en = de;
    @(posedge clk);
    #1;
  endtask

  // reset asserted between edges, with a request still presented
  task automatic mid_reset();
    #2 rst = 1;
    #1;
    chk("async_reg_write", q.reg_write, 0);
    chk("async_count", q.count, 0);
    chk("async_w_data", q.w_data, 0);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    q.in_valid = 0; q.in_reg = 0; q.in_data = 0; q.drain_en = 0;
    q.r_reg1 = 3; q.r_reg2 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 3, 32'hDEADBEEF, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) drive(1, 5'(i), 32'(i * 'h11), 0);
    repeat (5) drive(0, 0, 0, 1);
    q.r_reg1 = 7; q.r_reg2 = 8;
    drive(1, 7, 32'hA, 0);
    drive(1, 7, 32'hB, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 5'(i), $urandom, 1);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 5'(i + 1), $urandom, 0);
    q.in_valid = 1;
    q.drain_en = 1;
    mid_reset();
    repeat (3) drive(0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      q.r_reg1 = 5'($urandom_range(0, 7));
      q.r_reg2 = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) mid_reset();
      else drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1);
    end
    repeat (6) drive(0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
